// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core pipeline: ALU command encodings,
// NZCV bit positions and the control bundle carried from ID to EXE.
package arm_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    typedef struct packed {
        logic wb_en;
        logic mem_r;
        logic mem_w;
        logic b;
        logic s;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // A failed condition strips every side effect of the instruction.
    function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic pass);
        return pass ? c : CTRL_NOP;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones.
// Ports: clk, rst_n (async low), inc, hold (freezes count), cnt.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         hold,
    output logic [W-1:0] cnt
);

    logic at_max;

    assign at_max = (cnt == {W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !hold && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with condition-code squash, flush, freeze,
// bubble insertion and a saturating squashed-instruction counter.
// Ports: clk, rst_n, freeze, flush, hazard, check_cc, *_ID inputs,
// registered *_EXE outputs, carry_EXE, valid_EXE, squash_cnt.
module id_exe_reg
    import arm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic              hazard,
    input  logic              check_cc,
    input  logic [DATA_W-1:0] pc_ID,
    input  logic [DATA_W-1:0] val_rn_ID,
    input  logic [DATA_W-1:0] val_rm_ID,
    input  logic              imm_ID,
    input  logic [11:0]       shift_op_ID,
    input  logic [23:0]       imm24_ID,
    input  logic [3:0]        dest_ID,
    input  logic [3:0]        src1_ID,
    input  logic [3:0]        src2_ID,
    input  logic [3:0]        exe_cmd_ID,
    input  logic              wb_en_ID,
    input  logic              mem_r_ID,
    input  logic              mem_w_ID,
    input  logic              b_ID,
    input  logic              s_ID,
    input  logic [3:0]        status_ID,
    output logic [DATA_W-1:0] pc_EXE,
    output logic [DATA_W-1:0] val_rn_EXE,
    output logic [DATA_W-1:0] val_rm_EXE,
    output logic              imm_EXE,
    output logic [11:0]       shift_op_EXE,
    output logic [23:0]       imm24_EXE,
    output logic [3:0]        dest_EXE,
    output logic [3:0]        src1_EXE,
    output logic [3:0]        src2_EXE,
    output logic [3:0]        exe_cmd_EXE,
    output logic              wb_en_EXE,
    output logic              mem_r_EXE,
    output logic              mem_w_EXE,
    output logic              b_EXE,
    output logic              s_EXE,
    output logic [3:0]        status_EXE,
    output logic              carry_EXE,
    output logic              valid_EXE,
    output logic [CNT_W-1:0]  squash_cnt
);

    ctrl_t ctrl_id;
    ctrl_t ctrl_q;
    logic  capture;

    assign ctrl_id = '{wb_en: wb_en_ID, mem_r: mem_r_ID,
                       mem_w: mem_w_ID, b: b_ID, s: s_ID};
    assign capture = !flush && !freeze && !hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            pc_EXE       <= '0;
            val_rn_EXE   <= '0;
            val_rm_EXE   <= '0;
            imm_EXE      <= 1'b0;
            shift_op_EXE <= '0;
            imm24_EXE    <= '0;
            dest_EXE     <= '0;
            src1_EXE     <= '0;
            src2_EXE     <= '0;
            exe_cmd_EXE  <= '0;
            status_EXE   <= '0;
            carry_EXE    <= 1'b0;
            ctrl_q       <= CTRL_NOP;
            valid_EXE    <= 1'b0;
        end else if (!freeze) begin
            if (hazard) begin
                // Bubble: operands stay put, only side effects are killed.
                ctrl_q    <= CTRL_NOP;
                valid_EXE <= 1'b0;
            end else begin
                // Squashed instructions still load indices for forwarding.
                pc_EXE       <= pc_ID;
                val_rn_EXE   <= val_rn_ID;
                val_rm_EXE   <= val_rm_ID;
                imm_EXE      <= imm_ID;
                shift_op_EXE <= shift_op_ID;
                imm24_EXE    <= imm24_ID;
                dest_EXE     <= dest_ID;
                src1_EXE     <= src1_ID;
                src2_EXE     <= src2_ID;
                exe_cmd_EXE  <= exe_cmd_ID;
                status_EXE   <= status_ID;
                carry_EXE    <= status_ID[C_IDX];
                ctrl_q       <= gate_ctrl(ctrl_id, check_cc);
                valid_EXE    <= check_cc;
            end
        end
    end

    assign wb_en_EXE = ctrl_q.wb_en;
    assign mem_r_EXE = ctrl_q.mem_r;
    assign mem_w_EXE = ctrl_q.mem_w;
    assign b_EXE     = ctrl_q.b;
    assign s_EXE     = ctrl_q.s;

    sat_counter #(
        .W(CNT_W)
    ) u_squash_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (capture && !check_cc),
        .hold (freeze),
        .cnt  (squash_cnt)
    );

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed bench for id_exe_reg.
// Capture, squash, freeze, flush, hazard, saturation, reset.
module tb_id_exe_reg;

  logic        clk = 1'b0;
  logic        rst_n, freeze, flush;
  logic        hazard, check_cc;
  logic [31:0] pc_ID, val_rn_ID, val_rm_ID;
  logic        imm_ID;
  logic [11:0] shift_op_ID;
  logic [23:0] imm24_ID;
  logic [3:0]  dest_ID, src1_ID, src2_ID;
  logic [3:0]  exe_cmd_ID, status_ID;
  logic        wb_en_ID, mem_r_ID, mem_w_ID;
  logic        b_ID, s_ID;
  logic [31:0] pc_EXE, val_rn_EXE, val_rm_EXE;
  logic        imm_EXE;
  logic [11:0] shift_op_EXE;
  logic [23:0] imm24_EXE;
  logic [3:0]  dest_EXE, src1_EXE, src2_EXE;
  logic [3:0]  exe_cmd_EXE, status_EXE;
  logic        wb_en_EXE, mem_r_EXE, mem_w_EXE;
  logic        b_EXE, s_EXE;
  logic        carry_EXE, valid_EXE;
  logic [3:0]  squash_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_exe_reg #(.DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .freeze(freeze), .flush(flush),
    .hazard(hazard), .check_cc(check_cc),
    .pc_ID(pc_ID), .val_rn_ID(val_rn_ID),
    .val_rm_ID(val_rm_ID), .imm_ID(imm_ID),
    .shift_op_ID(shift_op_ID),
    .imm24_ID(imm24_ID), .dest_ID(dest_ID),
    .src1_ID(src1_ID), .src2_ID(src2_ID),
    .exe_cmd_ID(exe_cmd_ID),
    .wb_en_ID(wb_en_ID), .mem_r_ID(mem_r_ID),
    .mem_w_ID(mem_w_ID), .b_ID(b_ID),
    .s_ID(s_ID), .status_ID(status_ID),
    .pc_EXE(pc_EXE), .val_rn_EXE(val_rn_EXE),
    .val_rm_EXE(val_rm_EXE), .imm_EXE(imm_EXE),
    .shift_op_EXE(shift_op_EXE),
    .imm24_EXE(imm24_EXE), .dest_EXE(dest_EXE),
    .src1_EXE(src1_EXE), .src2_EXE(src2_EXE),
    .exe_cmd_EXE(exe_cmd_EXE),
    .wb_en_EXE(wb_en_EXE),
    .mem_r_EXE(mem_r_EXE),
    .mem_w_EXE(mem_w_EXE), .b_EXE(b_EXE),
    .s_EXE(s_EXE), .status_EXE(status_EXE),
    .carry_EXE(carry_EXE),
    .valid_EXE(valid_EXE),
    .squash_cnt(squash_cnt)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    freeze = 0; flush = 0;
    hazard = 0; check_cc = 0;
    pc_ID = '0; val_rn_ID = '0;
    val_rm_ID = '0; imm_ID = 0;
    shift_op_ID = '0; imm24_ID = '0;
    dest_ID = '0; src1_ID = '0;
    src2_ID = '0; exe_cmd_ID = '0;
    status_ID = '0;
    wb_en_ID = 0; mem_r_ID = 0;
    mem_w_ID = 0; b_ID = 0; s_ID = 0;
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    pc_ID = 32'h44; dest_ID = 4'h6;
    wb_en_ID = 1; check_cc = 1;
    #2;
    chk("rst_dest", dest_EXE, 4'h0);
    chk("rst_valid", valid_EXE, 1'b0);
    chk("rst_cnt", squash_cnt, 4'h0);
    rst_n = 1;

    clear_inputs();
    check_cc = 1; wb_en_ID = 1;
    dest_ID = 4'h5;
    val_rn_ID = 32'hDEADBEEF;
    status_ID = 4'b0010;
    pc_ID = 32'h0000_0104;
    imm24_ID = 24'hABCDEF;
    step();
    chk("cap_wb", wb_en_EXE, 1'b1);
    chk("cap_dest", dest_EXE, 4'h5);
    chk("cap_rn", val_rn_EXE, 32'hDEADBEEF);
    chk("cap_carry", carry_EXE, 1'b1);
    chk("cap_valid", valid_EXE, 1'b1);
    chk("cap_pc", pc_EXE, 32'h0000_0104);
    chk("cap_imm24", imm24_EXE, 24'hABCDEF);

    clear_inputs();
    check_cc = 0; wb_en_ID = 1;
    mem_w_ID = 1; b_ID = 1; s_ID = 1;
    dest_ID = 4'h3;
    val_rn_ID = 32'h1111_2222;
    step();
    chk("sq_memw", mem_w_EXE, 1'b0);
    chk("sq_b", b_EXE, 1'b0);
    chk("sq_wb", wb_en_EXE, 1'b0);
    chk("sq_s", s_EXE, 1'b0);
    chk("sq_valid", valid_EXE, 1'b0);
    chk("sq_dest", dest_EXE, 4'h3);
    chk("sq_rn", val_rn_EXE, 32'h1111_2222);
    chk("sq_cnt", squash_cnt, 4'h1);

    clear_inputs();
    check_cc = 1; wb_en_ID = 1;
    mem_r_ID = 1; s_ID = 1;
    dest_ID = 4'h7;
    val_rm_ID = 32'hA5A5_A5A5;
    status_ID = 4'b1111;
    step();
    chk("live_memr", mem_r_EXE, 1'b1);
    chk("live_s", s_EXE, 1'b1);

    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      freeze = 1; check_cc = 0;
      mem_w_ID = 1;
      dest_ID = 4'(i + 10);
      val_rm_ID = 32'(i * 32'h0101_0101);
      step();
      chk("frz_dest", dest_EXE, 4'h7);
      chk("frz_rm", val_rm_EXE,
          32'hA5A5_A5A5);
      chk("frz_wb", wb_en_EXE, 1'b1);
      chk("frz_valid", valid_EXE, 1'b1);
      chk("frz_carry", carry_EXE, 1'b1);
      chk("frz_cnt", squash_cnt, 4'h1);
    end

    clear_inputs();
    freeze = 1; flush = 1; check_cc = 0;
    dest_ID = 4'hC;
    val_rm_ID = 32'h1234_5678;
    wb_en_ID = 1;
    step();
    chk("fl_dest", dest_EXE, 4'h0);
    chk("fl_rm", val_rm_EXE, 32'h0);
    chk("fl_wb", wb_en_EXE, 1'b0);
    chk("fl_memr", mem_r_EXE, 1'b0);
    chk("fl_valid", valid_EXE, 1'b0);
    chk("fl_carry", carry_EXE, 1'b0);
    chk("fl_status", status_EXE, 4'h0);
    chk("fl_cnt", squash_cnt, 4'h1);

    clear_inputs();
    check_cc = 1; wb_en_ID = 1;
    mem_w_ID = 1; dest_ID = 4'h9;
    val_rn_ID = 32'hCAFE_F00D;
    status_ID = 4'b0010;
    exe_cmd_ID = 4'b0010;
    step();
    chk("pre_hz_memw", mem_w_EXE, 1'b1);
    clear_inputs();
    hazard = 1; check_cc = 0;
    dest_ID = 4'h2; wb_en_ID = 1;
    step();
    chk("hz_dest", dest_EXE, 4'h9);
    chk("hz_rn", val_rn_EXE, 32'hCAFE_F00D);
    chk("hz_cmd", exe_cmd_EXE, 4'b0010);
    chk("hz_carry", carry_EXE, 1'b1);
    chk("hz_wb", wb_en_EXE, 1'b0);
    chk("hz_memw", mem_w_EXE, 1'b0);
    chk("hz_valid", valid_EXE, 1'b0);
    chk("hz_cnt", squash_cnt, 4'h1);

    clear_inputs();
    hazard = 1; flush = 1;
    check_cc = 1; dest_ID = 4'hE;
    step();
    chk("flhz_dest", dest_EXE, 4'h0);
    chk("flhz_rn", val_rn_EXE, 32'h0);
    chk("flhz_valid", valid_EXE, 1'b0);
    chk("flhz_cnt", squash_cnt, 4'h1);

    clear_inputs();
    check_cc = 0; wb_en_ID = 1;
    for (int i = 1; i <= 20; i++) begin
      dest_ID = 4'(i);
      step();
      if (i == 10) begin
        chk("sat_mid", squash_cnt, 4'hB);
      end
    end
    chk("sat_end", squash_cnt, 4'hF);
    chk("sat_dest", dest_EXE, 4'(20));
    chk("sat_wb", wb_en_EXE, 1'b0);

    clear_inputs();
    check_cc = 1; wb_en_ID = 1;
    dest_ID = 4'h5;
    val_rn_ID = 32'hDEADBEEF;
    step();
    chk("pre_rst_valid", valid_EXE, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("arst_dest", dest_EXE, 4'h0);
    chk("arst_rn", val_rn_EXE, 32'h0);
    chk("arst_wb", wb_en_EXE, 1'b0);
    chk("arst_valid", valid_EXE, 1'b0);
    chk("arst_cnt", squash_cnt, 4'h0);
    step();
    rst_n = 1;
    step();
    chk("post_rst_dest", dest_EXE, 4'h5);
    chk("post_rst_valid", valid_EXE, 1'b1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/id_exe_reg.md
Name: id_exe_reg

Overview:
- Pipeline register between the ID stage and the EXE stage of the 32-bit ARM core.
- Captures decoded operands, control signals and the ID-stage NZCV snapshot each cycle.
- Uses the condition-check result (check_cc) to squash control side effects of failed-condition instructions.
- Implements flush (taken branch), freeze (global stall) and bubble insertion (load-use hazard), plus a saturating squashed-instruction counter for performance monitoring.

Parameters:
- DATA_W, 32, width of PC and register operand fields
- CNT_W, 16, width of squash performance counter

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- freeze  in  1  global stall; hold all state
- flush  in  1  taken branch resolved in EXE; kill the instruction entering EXE
- hazard  in  1  load-use hazard; insert bubble into EXE
- check_cc  in  1  condition-check result for the instruction in ID
- pc_ID  in  DATA_W  PC+4 of the ID instruction
- val_rn_ID, val_rm_ID  in  DATA_W  register-file read values
- imm_ID  in  1  immediate-operand flag
- shift_op_ID  in  12  shifter operand field
- imm24_ID  in  24  branch offset
- dest_ID, src1_ID, src2_ID  in  4  register indices
- exe_cmd_ID  in  4  ALU command
- wb_en_ID, mem_r_ID, mem_w_ID, b_ID, s_ID  in  1  control signals
- status_ID  in  4  NZCV snapshot ({N,Z,C,V})
- All above data/control fields with _EXE suffix  out  same widths  registered copies
- carry_EXE  out  1  registered C bit (status_ID[1]) for ALU carry-in
- valid_EXE  out  1  EXE holds a live, condition-passed instruction
- squash_cnt  out  CNT_W  count of condition-failed instructions squashed

Behaviour:
- Reset (rst_n=0, asynchronous): every output is 0, squash_cnt is 0. Release takes effect on the next rising edge; the first capture occurs on the first edge with rst_n=1.
- Let kill_ID = !check_cc.
- Per-edge priority, highest first:
  1. flush=1: load a bubble. All control outputs (wb_en, mem_r, mem_w, b, s) are 0, valid_EXE=0, and data fields are 0. Flush overrides freeze.
  2. freeze=1: hold every register, including squash_cnt.
  3. hazard=1: load a bubble. Data fields keep their old values; control outputs are 0 and valid_EXE=0.
  4. Otherwise, normal capture:
     - All data fields take their _ID values.
     - Control outputs take their _ID values ANDed with check_cc.
     - valid_EXE = check_cc.
     - carry_EXE = status_ID[1].
- Squashed instructions (check_cc=0, normal capture): dest/src/operands still load so forwarding logic sees consistent indices, but wb_en, mem_r, mem_w, b and s are 0. A failed-condition instruction never writes registers or memory, branches, or updates flags.
- squash_cnt:
  - Increments by 1 only on a normal-capture edge with check_cc=0.
  - Saturates at all-ones; no wrap.
  - Does not change on flush, freeze or hazard edges.
- Latency: exactly 1 cycle from ID inputs to _EXE outputs. No combinational path from any input to any output.
- Simultaneous flush and hazard: flush wins; the result is the same bubble, with data zeroed.
- check_cc is don't-care during flush, freeze and hazard.

Decomposition:
- Shared package (arm_pkg):
  - exe_cmd encodings (MOV=0001, ADD=0010, … as used by the ALU)
  - NZCV bit-index constants N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0
  - struct ctrl_t {wb_en, mem_r, mem_w, b, s}, so that the bubble value is a single named constant CTRL_NOP.
- One natural sub-module: sat_counter (width-parameterised saturating counter with inc and hold), instantiated once for squash_cnt.

Test Plan:
1. Reset mid-operation: drive a live instruction, assert rst_n=0 between edges -> all outputs 0 immediately, squash_cnt=0.
2. Normal capture: check_cc=1, wb_en_ID=1, dest_ID=4'h5, val_rn_ID=32'hDEADBEEF, status_ID=4'b0010 -> next edge: wb_en_EXE=1, dest_EXE=5, val_rn_EXE=DEADBEEF, carry_EXE=1, valid_EXE=1.
3. Squash: check_cc=0, mem_w_ID=1, b_ID=1, dest_ID=3 -> mem_w_EXE=0, b_EXE=0, valid_EXE=0, dest_EXE=3, squash_cnt increments 0->1.
4. Freeze vs flush: freeze=1 for 3 cycles with changing inputs -> outputs constant; then freeze=1 with flush=1 -> bubble loaded, valid_EXE=0, data 0.
5. Hazard bubble: hazard=1, check_cc=0 -> controls 0, data held, squash_cnt unchanged.
6. Saturation: CNT_W=4, apply 20 consecutive squashed captures -> squash_cnt stops at 4'hF.
